// File: rtl/gp_register_file_if.sv
// Control and status signals of the general-purpose register file.
// The register file uses the slave modport and the driving block uses the master modport.
interface gp_register_file_if #(
  parameter int unsigned SELW = 2
) ();
  logic [SELW-1:0] load_sel;
  logic [SELW-1:0] out_sel;
  logic [SELW-1:0] l_sel;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] cnt_sel;
  logic            loadn;
  logic            outn;
  logic            lsnapn;
  logic            loutn;
  logic            routn;
  logic            incn;
  logic            decn;
  logic            cnt_wrap;

  modport master (
    output load_sel, out_sel, l_sel, r_sel, cnt_sel,
    output loadn, outn, lsnapn, loutn, routn, incn, decn,
    input  cnt_wrap
  );

  modport slave (
    input  load_sel, out_sel, l_sel, r_sel, cnt_sel,
    input  loadn, outn, lsnapn, loutn, routn, incn, decn,
    output cnt_wrap
  );
endinterface

// File: rtl/gp_register_file.sv
// NREGS x WIDTH register file with a shared tri-state bus, a snapshot ALU LHS, a live ALU RHS
// and in-place inc/dec with a wrap pulse. The tri-state nets are plain ports.
module gp_register_file #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  gp_register_file_if.slave io,
  inout  wire  [WIDTH-1:0]  bus,
  output wire  [WIDTH-1:0]  alu_l,
  output wire  [WIDTH-1:0]  alu_r
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_snap;
  logic             r_cnt_wrap;

  logic [WIDTH-1:0] w_out_val;
  logic [WIDTH-1:0] w_l_val;
  logic [WIDTH-1:0] w_r_val;
  logic [WIDTH-1:0] w_cnt_val;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_cnt_hit;
  logic             w_cnt_op;
  logic             w_cnt_blocked;
  logic             w_wrap_d;
  logic [NREGS-1:0] w_load_en;
  logic [NREGS-1:0] w_cnt_en;

  // Out-of-range selects match no register and therefore read as zero.
  always_comb begin
    w_out_val = '0;
    w_l_val   = '0;
    w_r_val   = '0;
    w_cnt_val = '0;
    w_cnt_hit = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (io.out_sel == SELW'(i)) w_out_val = r_regs[i];
      if (io.l_sel == SELW'(i))   w_l_val   = r_regs[i];
      if (io.r_sel == SELW'(i))   w_r_val   = r_regs[i];
      if (io.cnt_sel == SELW'(i)) begin
        w_cnt_val = r_regs[i];
        w_cnt_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_cnt_op      = io.incn ^ io.decn;
    w_cnt_blocked = !io.loadn && (io.load_sel == io.cnt_sel);
    w_cnt_next    = io.incn ? (w_cnt_val - WIDTH'(1)) : (w_cnt_val + WIDTH'(1));
    w_wrap_d      = w_cnt_hit && w_cnt_op && !w_cnt_blocked &&
                    (io.incn ? (w_cnt_val == '0) : (w_cnt_val == '1));
    for (int i = 0; i < NREGS; i++) begin
      w_load_en[i] = !io.loadn && (io.load_sel == SELW'(i));
      w_cnt_en[i]  = w_cnt_op && !w_cnt_blocked && (io.cnt_sel == SELW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_snap     <= '0;
      r_cnt_wrap <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_load_en[i]) begin
          r_regs[i] <= bus;
        end else if (w_cnt_en[i]) begin
          r_regs[i] <= w_cnt_next;
        end
      end
      if (!io.lsnapn) r_snap <= w_l_val;
      r_cnt_wrap <= w_wrap_d;
    end
  end

  assign bus         = io.outn  ? {WIDTH{1'bz}} : w_out_val;
  assign alu_l       = io.loutn ? {WIDTH{1'bz}} : r_snap;
  assign alu_r       = io.routn ? {WIDTH{1'bz}} : w_r_val;
  assign io.cnt_wrap = r_cnt_wrap;

endmodule

// File: tb/tb_gp_register_file.sv
// Bench for gp_register_file: a 4-register and a 3-register instance share one stimulus stream
// and are compared against an array-based reference model.
`timescale 1ns/1ps
module tb_gp_register_file;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] load_sel, out_sel, l_sel, r_sel, cnt_sel;
  logic       loadn, outn, lsnapn, loutn, routn, incn, decn;
  logic [7:0] bus_val;
  logic       bus_en;

  wire  [7:0] bus0, bus1, alu_l0, alu_l1, alu_r0, alu_r1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: index 0 is the 4-register instance, index 1 the 3-register one.
  logic [7:0] m_regs [2][4];
  logic [7:0] m_snap [2];
  logic       m_wrap [2];
  int         m_n    [2] = '{4, 3};

  always #10 clk = ~clk;

  gp_register_file_if #(.SELW(2)) u_if0 ();
  gp_register_file_if #(.SELW(2)) u_if1 ();

  assign u_if0.load_sel = load_sel;  assign u_if1.load_sel = load_sel;
  assign u_if0.out_sel  = out_sel;   assign u_if1.out_sel  = out_sel;
  assign u_if0.l_sel    = l_sel;     assign u_if1.l_sel    = l_sel;
  assign u_if0.r_sel    = r_sel;     assign u_if1.r_sel    = r_sel;
  assign u_if0.cnt_sel  = cnt_sel;   assign u_if1.cnt_sel  = cnt_sel;
  assign u_if0.loadn    = loadn;     assign u_if1.loadn    = loadn;
  assign u_if0.outn     = outn;      assign u_if1.outn     = outn;
  assign u_if0.lsnapn   = lsnapn;    assign u_if1.lsnapn   = lsnapn;
  assign u_if0.loutn    = loutn;     assign u_if1.loutn    = loutn;
  assign u_if0.routn    = routn;     assign u_if1.routn    = routn;
  assign u_if0.incn     = incn;      assign u_if1.incn     = incn;
  assign u_if0.decn     = decn;      assign u_if1.decn     = decn;

  assign bus0 = bus_en ? bus_val : 8'hzz;
  assign bus1 = bus_en ? bus_val : 8'hzz;

  gp_register_file #(.WIDTH(8), .NREGS(4), .SELW(2)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .io    (u_if0),
    .bus   (bus0),
    .alu_l (alu_l0),
    .alu_r (alu_r0)
  );

  gp_register_file #(.WIDTH(8), .NREGS(3), .SELW(2)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .io    (u_if1),
    .bus   (bus1),
    .alu_l (alu_l1),
    .alu_r (alu_r1)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] rd(input int k, input int s);
    return (s < m_n[k]) ? m_regs[k][s] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) m_regs[k][s] = 8'h00;
      m_snap[k] = 8'h00;
      m_wrap[k] = 1'b0;
    end
  endtask

  task automatic idle();
    loadn = 1'b1; outn = 1'b1; lsnapn = 1'b1; loutn = 1'b1;
    routn = 1'b1; incn = 1'b1; decn = 1'b1; bus_en = 1'b1;
  endtask

  task automatic check_inst(input int k, input logic [7:0] b, input logic [7:0] al,
                            input logic [7:0] ar, input logic w);
    string p;
    p = (k == 0) ? "r4" : "r3";
    check_eq({p, "_wrap"}, {31'b0, w}, {31'b0, m_wrap[k]});
    if (!loutn) check_eq({p, "_alu_l"}, {24'b0, al}, {24'b0, m_snap[k]});
    if (!routn) check_eq({p, "_alu_r"}, {24'b0, ar}, {24'b0, rd(k, int'(r_sel))});
    check_eq({p, "_bus"}, {24'b0, b}, {24'b0, outn ? bus_val : rd(k, int'(out_sel))});
  endtask

  // Applies the current controls across one rising edge, then checks both instances.
  task automatic tick();
    logic [7:0] nr [2][4];
    logic [7:0] ns [2];
    logic       nw [2];
    logic [7:0] busv;
    int         v;
    bus_en = outn;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) nr[k][s] = m_regs[k][s];
      busv  = outn ? bus_val : rd(k, int'(out_sel));
      ns[k] = lsnapn ? m_snap[k] : rd(k, int'(l_sel));
      nw[k] = 1'b0;
      if ((incn != decn) && (int'(cnt_sel) < m_n[k]) && !(!loadn && load_sel == cnt_sel)) begin
        v = int'(m_regs[k][cnt_sel]);
        if (!incn) begin
          nr[k][cnt_sel] = 8'((v + 1) % 256);
          nw[k] = (v == 255);
        end else begin
          nr[k][cnt_sel] = 8'((v + 255) % 256);
          nw[k] = (v == 0);
        end
      end
      if (!loadn && int'(load_sel) < m_n[k]) nr[k][load_sel] = busv;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) m_regs[k][s] = nr[k][s];
      m_snap[k] = ns[k];
      m_wrap[k] = nw[k];
    end
    check_inst(0, bus0, alu_l0, alu_r0, u_if0.cnt_wrap);
    check_inst(1, bus1, alu_l1, alu_r1, u_if1.cnt_wrap);
  endtask

  task automatic dump_regs();
    outn = 1'b0;
    bus_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      out_sel = 2'(s);
      #1;
      check_eq($sformatf("r4_reg%0d", s), {24'b0, bus0}, {24'b0, rd(0, s)});
      check_eq($sformatf("r3_reg%0d", s), {24'b0, bus1}, {24'b0, rd(1, s)});
    end
    outn = 1'b1;
    bus_en = 1'b1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] val);
    idle();
    load_sel = sel; loadn = 1'b0; bus_val = val;
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    load_sel = '0; out_sel = '0; l_sel = '0; r_sel = '0; cnt_sel = '0;
    bus_val = 8'haa;
    model_reset();

    // Reset state: undriven DUT leaves the bench's value on the bus.
    #2;
    check_eq("rst_bus_released", {24'b0, bus0}, 32'haa);
    check_eq("rst_wrap", {31'b0, u_if0.cnt_wrap}, 32'h0);
    outn = 1'b0; bus_en = 1'b0; out_sel = 2'd2;
    #1 check_eq("rst_bus_reg2", {24'b0, bus0}, 32'h00);
    loutn = 1'b0;
    #1 check_eq("rst_alu_l", {24'b0, alu_l0}, 32'h00);
    reset = 1'b0;
    idle();

    // Bus load and read-back.
    load(2'd1, 8'h3a);
    outn = 1'b0; bus_en = 1'b0; out_sel = 2'd1; routn = 1'b0; r_sel = 2'd1;
    #1;
    check_eq("load_bus", {24'b0, bus0}, 32'h3a);
    check_eq("load_alu_r", {24'b0, alu_r0}, 32'h3a);
    idle();

    // Snapshot holds while the source register changes.
    lsnapn = 1'b0; l_sel = 2'd1;
    tick();
    idle();
    load(2'd1, 8'h55);
    loutn = 1'b0; routn = 1'b0; r_sel = 2'd1;
    #1;
    check_eq("snap_hold", {24'b0, alu_l0}, 32'h3a);
    check_eq("snap_live_r", {24'b0, alu_r0}, 32'h55);
    lsnapn = 1'b0;
    tick();
    check_eq("snap_recapture", {24'b0, alu_l0}, 32'h55);
    idle();

    // Wrap on increment and decrement; reg3 is out of range for the 3-register instance.
    load(2'd3, 8'hff);
    incn = 1'b0; cnt_sel = 2'd3;
    tick();
    check_eq("inc_wrap", {31'b0, u_if0.cnt_wrap}, 32'h1);
    check_eq("oor_cnt_no_wrap", {31'b0, u_if1.cnt_wrap}, 32'h0);
    idle();
    tick();
    check_eq("wrap_one_cycle", {31'b0, u_if0.cnt_wrap}, 32'h0);
    decn = 1'b0;
    tick();
    check_eq("dec_wrap", {31'b0, u_if0.cnt_wrap}, 32'h1);
    incn = 1'b0;
    tick();
    check_eq("both_low_no_wrap", {31'b0, u_if0.cnt_wrap}, 32'h0);
    idle();
    dump_regs();

    // Load beats inc/dec on the same register; different registers act independently.
    load(2'd2, 8'h07);
    load_sel = 2'd0; loadn = 1'b0; bus_val = 8'h10; incn = 1'b0; cnt_sel = 2'd0;
    tick();
    idle();
    load_sel = 2'd0; loadn = 1'b0; bus_val = 8'h10; incn = 1'b0; cnt_sel = 2'd2;
    tick();
    idle();
    outn = 1'b0; bus_en = 1'b0; out_sel = 2'd0;
    #1 check_eq("load_wins_reg0", {24'b0, bus0}, 32'h10);
    out_sel = 2'd2;
    #1 check_eq("indep_inc_reg2", {24'b0, bus0}, 32'h08);
    idle();
    dump_regs();

    // Out-of-range select on the 3-register instance.
    load(2'd3, 8'h5c);
    outn = 1'b0; bus_en = 1'b0; out_sel = 2'd3;
    #1 check_eq("oor_bus_zero", {24'b0, bus1}, 32'h00);
    idle();
    dump_regs();

    // Asynchronous reset mid-cycle clears the wrap pulse and snapshot at once.
    load(2'd1, 8'hff);
    lsnapn = 1'b0; l_sel = 2'd1;
    tick();
    idle();
    incn = 1'b0; cnt_sel = 2'd1;
    tick();
    idle();
    loutn = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_wrap", {31'b0, u_if0.cnt_wrap}, 32'h0);
    check_eq("async_rst_alu_l", {24'b0, alu_l0}, 32'h00);
    // Load pending while reset is held is lost.
    loadn = 1'b0; load_sel = 2'd0; bus_val = 8'h77;
    @(posedge clk);
    #2 reset = 1'b0;
    idle();
    dump_regs();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [1:0] pick;
      idle();
      load_sel = 2'($urandom_range(0, 3));
      out_sel  = 2'($urandom_range(0, 3));
      l_sel    = 2'($urandom_range(0, 3));
      r_sel    = 2'($urandom_range(0, 3));
      cnt_sel  = 2'($urandom_range(0, 3));
      loadn    = ($urandom_range(0, 2) != 0);
      outn     = ($urandom_range(0, 2) != 0);
      lsnapn   = ($urandom_range(0, 3) != 0);
      loutn    = $urandom_range(0, 1) != 0;
      routn    = $urandom_range(0, 1) != 0;
      incn     = $urandom_range(0, 1) != 0;
      decn     = $urandom_range(0, 1) != 0;
      pick     = 2'($urandom_range(0, 3));
      bus_val  = (pick == 2'd0) ? 8'hff : (pick == 2'd1) ? 8'h00 : 8'($urandom);
      tick();
      if (c % 25 == 24) dump_regs();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gp_register_file.md
Name: gp_register_file

Overview:
- Parametrised successor to the single general-purpose register.
- Holds NREGS registers of WIDTH bits behind one shared tri-state data bus.
- Per-port select for bus load, bus output, ALU LHS (snapshot-latched) and ALU RHS (live).
- Adds in-place increment/decrement with a registered wrap flag, for counters and pointers (SP, loop counters) without ALU traffic.

Parameters:
WIDTH, 8, data width of every register, the bus and the ALU ports
NREGS, 4, number of registers; legal range 2..2**SELW
SELW, 2, register select width; must satisfy 2**SELW >= NREGS

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous reset, active-high
bus  inout  WIDTH  shared data bus, tri-stated when not driving
load_sel  input  SELW  destination register for bus load
loadn  input  1  active-low load from bus
out_sel  input  SELW  register driven onto bus
outn  input  1  active-low bus output enable
l_sel  input  SELW  register captured into LHS snapshot
lsnapn  input  1  active-low LHS snapshot capture
loutn  input  1  active-low ALU LHS output enable
r_sel  input  SELW  register driven on ALU RHS
routn  input  1  active-low ALU RHS output enable
cnt_sel  input  SELW  register targeted by inc/dec
incn  input  1  active-low increment
decn  input  1  active-low decrement
alu_l  output  WIDTH  ALU LHS, tri-state
alu_r  output  WIDTH  ALU RHS, tri-state
cnt_wrap  output  1  registered one-cycle wrap pulse

Behaviour:
- Reset (async, immediate on assertion): all registers = 0, LHS snapshot = 0, cnt_wrap = 0. While reset is high, loads, snapshots and inc/dec are ignored.
- Tri-state outputs are combinational from the enables, not reset:
  - bus = reg[out_sel] when outn=0, else Z.
  - alu_l = snapshot when loutn=0, else Z.
  - alu_r = reg[r_sel] (live) when routn=0, else Z.
- Load: at posedge with loadn=0, reg[load_sel] <= bus. Latency 1; the new value is visible on outputs after the edge. If the bus is undriven (Z), the register captures X.
- Snapshot: at posedge with lsnapn=0, snapshot <= reg[l_sel], sampled pre-edge. It holds until the next capture, and register changes do not affect it.
- Increment/decrement: at posedge, on reg[cnt_sel]:
  - incn=0, decn=1: +1 modulo 2**WIDTH.
  - decn=0, incn=1: -1 modulo 2**WIDTH.
  - Both low: no change, no wrap.
- Wrap flag: cnt_wrap <= 1 for exactly one cycle after an inc from all-ones to 0 or a dec from 0 to all-ones; otherwise cnt_wrap <= 0.
- Same edge, same register:
  - Load beats inc/dec; the inc/dec is dropped and cnt_wrap <= 0.
  - Snapshot of a register being loaded or counted captures the old value.
  - outn=0 and loadn=0 with out_sel == load_sel: the register reloads its own value (unchanged).
- Different registers on the same edge: load, inc/dec and snapshot all take effect independently.
- Out-of-range select (>= NREGS): load and inc/dec ignored; bus, alu_r and the snapshot source read as 0.
- Read ports are independent: bus, alu_l and alu_r may all be enabled at once, including on the same register.
- Reset asserted mid-operation: state clears immediately. A pending load or inc/dec at that edge is lost. cnt_wrap drops to 0 at once.

Test Plan:
- Reset, then all enables high -> bus, alu_l, alu_r = Z. Set outn=0, out_sel=2 -> bus = 8'h00. Assert loutn=0 -> alu_l = 8'h00.
- Drive bus 8'h3a, load_sel=1, loadn=0, one clk -> outn=0, out_sel=1 gives bus = 8'h3a; routn=0, r_sel=1 gives alu_r = 8'h3a.
- lsnapn=0, l_sel=1, clk; then load 8'h55 into reg1 -> alu_l stays 8'h3a while alu_r = 8'h55. Recapture -> alu_l = 8'h55.
- Load reg3 = 8'hff; incn=0, cnt_sel=3, clk -> reg3 = 8'h00 and cnt_wrap = 1 for one cycle. decn=0, clk -> reg3 = 8'hff with cnt_wrap = 1. Both incn and decn low -> no change, cnt_wrap = 0.
- Same edge: loadn=0 with bus 8'h10, incn=0, load_sel=cnt_sel=0 -> reg0 = 8'h10 (load wins). Repeat with load_sel=0, cnt_sel=2 (reg2 = 8'h07) -> reg0 = 8'h10, reg2 = 8'h08.
- With registers loaded nonzero, pulse reset between edges -> every register reads 8'h00, alu_l (enabled) = 8'h00, cnt_wrap = 0. With NREGS=3, SELW=2, load_sel=3 -> no register changes; out_sel=3 gives bus = 8'h00.
